// File: rtl/supercar_scanner.sv
// Bouncing "Supercar" LED scanner driven by one-cycle step pulses, with a programmable end dwell.
// Optional build macro SUPERCAR_TRAIL_EN adds a trailing LED at the previous position.
module supercar_scanner #(
   parameter int unsigned N_LED = 8,
   parameter int unsigned DWELL = 0,
   parameter int unsigned POS_W = $clog2(N_LED)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             run_i,
   input  logic             step_i,
   output logic [N_LED-1:0] led_o,
   output logic [POS_W-1:0] pos_o,
   output logic             dir_o,
   output logic             edge_o
);

   localparam int unsigned DcntW = (DWELL > 0) ? $clog2(DWELL + 1) : 1;

   localparam logic [POS_W-1:0] PosZero  = '0;
   localparam logic [POS_W-1:0] PosOne   = POS_W'(1);
   localparam logic [POS_W-1:0] PosTop   = POS_W'(N_LED - 1);
   localparam logic [POS_W-1:0] PosTopM1 = POS_W'(N_LED - 2);
   localparam logic [DcntW-1:0] DcntOne  = DcntW'(1);
   localparam logic [DcntW-1:0] DcntMax  = DcntW'(DWELL);
   localparam logic [N_LED-1:0] LedOne   = N_LED'(1);
   // With two LEDs every turnaround lands directly on the opposite end.
   localparam logic             TwoLed   = (N_LED == 2);

   typedef enum logic [1:0] {
      StIdle,
      StUp,
      StDown
   } state_e;

   state_e             state_q, state_d;
   logic [POS_W-1:0]   pos_q,   pos_d;
   logic [DcntW-1:0]   dcnt_q,  dcnt_d;
   logic               dir_q,   dir_d;
   logic               edge_q,  edge_d;
   logic [N_LED-1:0]   led_q,   led_d;
`ifdef SUPERCAR_TRAIL_EN
   logic [POS_W-1:0]   prev_q,  prev_d;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         pos_q   <= '0;
         dcnt_q  <= '0;
         dir_q   <= 1'b0;
         edge_q  <= 1'b0;
         led_q   <= '0;
`ifdef SUPERCAR_TRAIL_EN
         prev_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
         dcnt_q  <= dcnt_d;
         dir_q   <= dir_d;
         edge_q  <= edge_d;
         led_q   <= led_d;
`ifdef SUPERCAR_TRAIL_EN
         prev_q  <= prev_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      dcnt_d  = dcnt_q;
      dir_d   = dir_q;
      edge_d  = 1'b0;
`ifdef SUPERCAR_TRAIL_EN
      prev_d  = prev_q;
`endif

      if (!run_i) begin
         state_d = StIdle;
         pos_d   = PosZero;
         dcnt_d  = '0;
         dir_d   = 1'b0;
`ifdef SUPERCAR_TRAIL_EN
         prev_d  = PosZero;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               state_d = StUp;
               pos_d   = PosZero;
               dcnt_d  = '0;
               dir_d   = 1'b0;
`ifdef SUPERCAR_TRAIL_EN
               prev_d  = PosZero;
`endif
            end
            StUp: begin
               if (step_i) begin
`ifdef SUPERCAR_TRAIL_EN
                  // A dwell step reloads the same position, collapsing the trail to one LED.
                  prev_d = pos_q;
`endif
                  if (pos_q != PosTop) begin
                     pos_d  = pos_q + PosOne;
                     edge_d = (pos_q == PosTopM1);
                  end else if (dcnt_q != DcntMax) begin
                     dcnt_d = dcnt_q + DcntOne;
                  end else begin
                     state_d = StDown;
                     pos_d   = PosTopM1;
                     dcnt_d  = '0;
                     dir_d   = 1'b1;
                     edge_d  = TwoLed;
                  end
               end
            end
            StDown: begin
               if (step_i) begin
`ifdef SUPERCAR_TRAIL_EN
                  prev_d = pos_q;
`endif
                  if (pos_q != PosZero) begin
                     pos_d  = pos_q - PosOne;
                     edge_d = (pos_q == PosOne);
                  end else if (dcnt_q != DcntMax) begin
                     dcnt_d = dcnt_q + DcntOne;
                  end else begin
                     state_d = StUp;
                     pos_d   = PosOne;
                     dcnt_d  = '0;
                     dir_d   = 1'b0;
                     edge_d  = TwoLed;
                  end
               end
            end
            default: begin
               state_d = StIdle;
               pos_d   = PosZero;
               dcnt_d  = '0;
               dir_d   = 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      led_d = '0;
      if (state_d != StIdle) begin
`ifdef SUPERCAR_TRAIL_EN
         led_d = (LedOne << pos_d) | (LedOne << prev_d);
`else
         led_d = LedOne << pos_d;
`endif
      end
   end

   assign led_o  = led_q;
   assign pos_o  = pos_q;
   assign dir_o  = dir_q;
   assign edge_o = edge_q;

endmodule

// File: doc/supercar_scanner.md
# supercar_scanner

Downstream consumer of the prescaler tick: converts the one-cycle `step` pulses into the bouncing "Supercar" LED pattern. The lit position walks from LED 0 to LED N_LED-1 and back, advancing one position per `step`, with a programmable dwell at each end. Outputs drive the LED bank directly and report position, direction and end-of-sweep events to the rest of the design.

## Interface
- `N_LED`, 8: number of LEDs; legal range 2..64.
- `DWELL`, 0: number of extra `step` pulses held at each end before reversing; legal range 0..255.
- `POS_W`, $clog2(N_LED): width of `pos`; derived, not overridden.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  level; 1 = scanning, 0 = forced to IDLE.
- `step`  in  1  one-cycle advance pulse, driven from the prescaler `p_e`.
- `led`  out  N_LED  LED drive, bit i = LED i.
- `pos`  out  POS_W  current lit position.
- `dir`  out  1  0 = moving up (toward MSB), 1 = moving down.
- `edge`  out  1  one-cycle pulse when `pos` reaches 0 or N_LED-1.

## Operation
- States: IDLE, UP, DOWN. Internal dwell counter `dcnt`, width max(1, $clog2(DWELL+1)).
- IDLE: `led`=0, `pos`=0, `dir`=0, `dcnt`=0; `step` ignored. `run`=1 -> UP with `pos`=0, so LED 0 is lit the next cycle.
- UP, `step`=1:
  - `pos`<N_LED-1: `pos`++.
  - `pos`==N_LED-1 and `dcnt`<DWELL: `dcnt`++, hold position.
  - `pos`==N_LED-1 and `dcnt`==DWELL: go to DOWN, `pos`<=N_LED-2, `dcnt`<=0, `dir`<=1.
- DOWN mirrors UP: decrement toward 0; at 0 apply the same dwell rule, then go to UP with `pos`<=1 and `dir`<=0.
- `step`=0: no state, `pos` or `dcnt` change.
- `run`=0 in any state: next cycle IDLE. `run` has priority over a simultaneous `step`.
- `edge`=1 for exactly one cycle, in the cycle where `pos` first takes the value N_LED-1 (UP) or 0 (DOWN) on a sweep. It does not reassert during dwell steps. The initial `pos`=0 on entry from IDLE does not assert `edge`.
- `led` = one-hot of `pos` in UP/DOWN and all zeros in IDLE; see Configuration.
- N_LED=2: the pattern alternates 0,1,0,1 with dwell applied at each end.

## Timing
- All outputs are registered. Reset values: `led`=0, `pos`=0, `dir`=0, `edge`=0, state IDLE.
- `step` sampled at edge k -> `pos`, `led`, `dir` and `edge` updated from edge k+1. Latency is 1 cycle.
- `run` rise at edge k -> `led`=1 (LED 0) from edge k+1.
- `rst` or `run` fall mid-sweep (including during a dwell) -> all outputs at IDLE values the next cycle. A new `run` restarts at `pos`=0 going UP.
- Back-to-back `step` on consecutive cycles is legal; each pulse advances once.
- Full period with DWELL=d: 2·(N_LED-1) + 2·d steps.

## Configuration
- `SUPERCAR_TRAIL_EN` defined: adds a `prev_pos` register, loaded with the old `pos` whenever `pos` changes and set to `pos` on entry from IDLE. `led` = onehot(`pos`) | onehot(`prev_pos`), giving two lit LEDs while moving and one lit LED after a dwell step or at start. `prev_pos` is cleared to 0 in IDLE.
- Macro not defined: no `prev_pos` register is built; `led` is strictly one-hot in UP/DOWN.
- `pos`, `dir`, `edge` and all timing are identical in both builds.

## Test plan
- Reset: assert `rst` with `run`=1 and `step`=1 -> next cycle `led`=0, `pos`=0, `dir`=0, `edge`=0.
- N_LED=4, DWELL=0, `run`=1, 8 steps -> `pos` sequence 1,2,3,2,1,0,1,2; `edge` high after the steps to 3 and to 0 only; `dir` changes to 1 at the step to 2.
- N_LED=4, DWELL=2 -> `pos` stays at 3 for two extra steps, then 2; `edge` pulses once at the arrival at 3.
- Simultaneous `run` fall and `step` at `pos`=2 -> next cycle IDLE with `led`=0. `run` re-raise -> `led`=4'b0001, `dir`=0.
- `step` pulses with `run`=0 -> outputs stay 0; no `edge`.
- SUPERCAR_TRAIL_EN, N_LED=4, DWELL=0: step to `pos`=1 -> `led`=4'b0011; step to `pos`=2 -> `led`=4'b0110. Without the macro -> `led`=4'b0010, then 4'b0100.
